// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the priority encoder slice.
// Holds the default request width and the encoded-width calculation.
package encoder_pkg;

   localparam int DEFAULT_DIN_W = 8;
   localparam int MIN_DIN_W     = 2;
   localparam int MAX_DIN_W     = 64;

   // Width of a binary index able to address every bit of a w-bit vector.
   function automatic int enc_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

   function automatic bit is_legal_width(input int w);
      return (w >= MIN_DIN_W) && (w <= MAX_DIN_W) && ((w & (w - 1)) == 0);
   endfunction

endpackage

// File: rtl/encoder_core.sv
// Combinational priority/occupancy logic: the highest set bit wins, and
// any/multi report whether one or more than one request bit is set.
module encoder_core
   import encoder_pkg::*;
#(
   parameter  int DIN_W  = DEFAULT_DIN_W,
   localparam int DOUT_W = enc_width(DIN_W)
) (
   input  logic [DIN_W-1:0]  din,
   output logic [DOUT_W-1:0] idx,
   output logic              any,
   output logic              multi
);

   // Clearing the lowest set bit leaves a non-zero value only when two or
   // more bits were set, which avoids a full popcount adder tree.
   logic [DIN_W-1:0] low_cleared;

   assign low_cleared = din & (din - DIN_W'(1));
   assign any         = |din;
   assign multi       = |low_cleared;

   always_comb begin
      // NOTE: idx gets a default before the loop so every path assigns it and no latch is inferred.
      idx = '0;
      for (int i = 0; i < DIN_W; i++) begin
         if (din[i]) begin
            idx = DOUT_W'(i);
         end
      end
   end

endmodule

// File: rtl/encoder.sv
// Registered priority encoder: captures din on enabled edges and presents
// the index of the highest set bit plus valid/multi-hot flags.
module encoder
   import encoder_pkg::*;
#(
   parameter  int DIN_W  = DEFAULT_DIN_W,
   localparam int DOUT_W = enc_width(DIN_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIN_W-1:0]  din,
   output logic [DOUT_W-1:0] dout,
   output logic              valid,
   output logic              multi_err
);

   if (!is_legal_width(DIN_W)) begin : g_bad_width
      $error("encoder: DIN_W must be a power of two between 2 and 64");
   end

   logic [DOUT_W-1:0] core_idx;
   logic              core_any;
   logic              core_multi;

   encoder_core #(
      .DIN_W (DIN_W)
   ) u_core (
      .din   (din),
      .idx   (core_idx),
      .any   (core_any),
      .multi (core_multi)
   );

   // Outputs come straight from these flops; reset wins over en and drops
   // whatever would have been captured on that edge.
   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         dout      <= '0;
         valid     <= 1'b0;
         multi_err <= 1'b0;
      end else if (en) begin
         dout      <= core_idx;
         valid     <= core_any;
         multi_err <= core_multi;
      end
   end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: directed spec vectors followed by
// randomized traffic compared against an arithmetic reference model.
module tb_encoder;
   import encoder_pkg::*;

   localparam int W  = DEFAULT_DIN_W;
   localparam int OW = enc_width(W);

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    = 1'b0;
   logic [W-1:0]  din   = '0;
   logic [OW-1:0] dout;
   logic          valid;
   logic          multi_err;

   int total = 0;
   int bad   = 0;

   logic [OW-1:0] m_dout  = '0;
   logic          m_valid = 1'b0;
   logic          m_multi = 1'b0;

   always #5 clk = ~clk;

   encoder #(.DIN_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .din       (din),
      .dout      (dout),
      .valid     (valid),
      .multi_err (multi_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: MSB index of d is clog2(d+1)-1; multi-hot means more than one bit counted.
   task automatic model(input logic r, input logic e, input logic [W-1:0] d);
      logic [W:0] ext;
      if (!r) begin
         m_dout = '0; m_valid = 1'b0; m_multi = 1'b0;
      end else if (e) begin
         ext     = {1'b0, d} + 1'b1;
         m_valid = (d != '0);
         m_multi = ($countones(d) > 1);
         m_dout  = m_valid ? OW'($clog2(ext) - 1) : '0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_dout"},  64'(dout),      64'(m_dout));
      check({tag, "_valid"}, 64'(valid),     64'(m_valid));
      check({tag, "_multi"}, 64'(multi_err), 64'(m_multi));
   endtask

   // Apply inputs, take one edge, then sample 1 time unit later.
   task automatic step(input logic r, input logic e, input logic [W-1:0] d, input string tag);
      rst_n = r; en = e; din = d;
      @(posedge clk);
      #1;
      model(r, e, d);
      check_all(tag);
   endtask

   initial begin
      logic [W-1:0] rd;
      logic         re;
      logic         rr;

      // Reset walk with everything asserted.
      step(1'b0, 1'b1, 8'hFF, "rst0");
      step(1'b0, 1'b1, 8'hFF, "rst1");
      check("rst_const_valid", 64'(valid), 64'd0);

      // One-hot walk.
      for (int i = 0; i < W; i++) begin
         step(1'b1, 1'b1, W'(1) << i, $sformatf("onehot%0d", i));
         check($sformatf("onehot%0d_const", i), 64'(dout), 64'(i));
      end

      step(1'b1, 1'b1, 8'h00, "zero");

      step(1'b1, 1'b1, 8'hA0, "mh_a0");
      check("mh_a0_const", 64'({dout, valid, multi_err}), 64'({3'd7, 1'b1, 1'b1}));
      step(1'b1, 1'b1, 8'h06, "mh_06");
      check("mh_06_const", 64'({dout, valid, multi_err}), 64'({3'd2, 1'b1, 1'b1}));

      // Hold with en low.
      step(1'b1, 1'b1, 8'h10, "hold_cap");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h01, $sformatf("hold%0d", i));
         check($sformatf("hold%0d_const", i), 64'({dout, valid}), 64'({3'd4, 1'b1}));
      end

      // Mid-stream reset discards the capture on that edge.
      step(1'b0, 1'b1, 8'h80, "midrst");
      check("midrst_const", 64'({dout, valid}), 64'({3'd0, 1'b0}));
      step(1'b1, 1'b1, 8'h80, "midrst_rel");
      check("midrst_rel_const", 64'(dout), 64'd7);

      // Randomized traffic, with din wiggled between edges.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(3, 0))
            0:       rd = '0;
            1:       rd = W'(1) << $urandom_range(W - 1, 0);
            default: rd = W'($urandom);
         endcase
         re = ($urandom_range(3, 0) != 0);
         rr = ($urandom_range(15, 0) != 0);
         step(rr, re, rd, $sformatf("rnd%0d", n));
         din = W'($urandom);
         en  = 1'b1;
         #2;
         check_all($sformatf("glitch%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder.md
ENCODER -- requirements
Module: encoder

Interface
REQ-001 Parameter: DIN_W, default 8, input vector width; legal values are powers of two, 2..64.
REQ-002 Parameter: DOUT_W, default $clog2(DIN_W) (3), encoded index width; derived, not overridden.
REQ-003 Port: clk  input  1  single rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: en  input  1  sample enable; when high, din is captured on the clock edge.
REQ-006 Port: din  input  DIN_W  one-hot request vector; bit i means index i.
REQ-007 Port: dout  output  DOUT_W  binary index of the selected din bit, registered.
REQ-008 Port: valid  output  1  registered; high when the captured din had at least one bit set.
REQ-009 Port: multi_err  output  1  registered; high when the captured din had two or more bits set.

Function
REQ-010 On each rising clk edge with rst_n=1 and en=1, the block SHALL register dout, valid and multi_err computed from din at that edge (latency exactly 1 cycle).
REQ-011 For one-hot din with bit i set, dout SHALL equal i, valid SHALL be 1 and multi_err SHALL be 0.
REQ-012 For multi-hot din, the block SHALL use highest-index-wins priority: dout = index of the most significant set bit, valid=1, multi_err=1.
REQ-013 For din all zeros, dout SHALL be 0, valid 0 and multi_err 0.
REQ-014 With en=0 (and rst_n=1), all outputs SHALL hold their previous values.
REQ-015 Outputs SHALL be driven only from flops, with no combinational path from din or en to any output.
REQ-016 Changes on din between clock edges SHALL have no effect on the outputs.

Reset
REQ-017 When rst_n=0 at a rising clk edge, dout SHALL become 0, valid 0 and multi_err 0, regardless of en and din.
REQ-018 Reset SHALL take priority over en.
REQ-019 Reset asserted mid-stream SHALL discard the value being captured on that edge.
REQ-020 The first capture after reset SHALL occur on the first edge with rst_n=1 and en=1.

Structure
REQ-021 A shared package encoder_pkg SHALL hold the default DIN_W constant and a function computing the encoded width.
REQ-022 The priority and popcount logic SHALL be one combinational sub-module, encoder_core (din -> idx, any, multi).
REQ-023 The top level encoder SHALL contain only encoder_core and the output register stage.

Verification
REQ-024 Reset walk: rst_n=0 for 2 cycles, with din=8'hFF and en=1 -> dout=0, valid=0 and multi_err=0 throughout.
REQ-025 One-hot walk: en=1; din=01,02,04,08,10,20,40,80 (hex) on consecutive edges -> dout=0..7 one cycle later, valid=1, multi_err=0.
REQ-026 Zero input: din=8'h00, en=1 -> next cycle dout=0, valid=0, multi_err=0.
REQ-027 Multi-hot: din=8'hA0 -> dout=7, valid=1, multi_err=1; din=8'h06 -> dout=2, valid=1, multi_err=1.
REQ-028 Hold: capture din=8'h10 (dout=4), then en=0 with din=8'h01 for 3 cycles -> dout remains 4, valid remains 1.
REQ-029 Mid-stream reset: din=8'h80, en=1, rst_n=0 on the same edge -> dout=0, valid=0; rst_n=1 on the next edge -> dout=7.
